instr_loader: RTL and testbench



---
 rtl/mips_pkg.sv | 23 ++
 rtl/instr_loader_byte_packer.sv | 39 +++
 rtl/instr_loader.sv | 242 ++++++++++++++++++++++++
 tb/tb_instr_loader.sv | 216 +++++++++++++++++++++
 4 files changed

// File: rtl/mips_pkg.sv
// Shared definitions for the instruction loader: loader states, memory
// address width, instruction word width and the checksum fold helper.
package mips_pkg;

    localparam int IMEM_ADDR_W = 11;
    localparam int WORD_W      = 32;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        HDR   = 3'd1,
        ENTRY = 3'd2,
        DATA  = 3'd3,
        CHK   = 3'd4,
        RUN   = 3'd5,
        ERR   = 3'd6
    } state_t;

    // Fold one stream byte into the running XOR checksum.
    function automatic logic [7:0] xor_fold(input logic [7:0] acc, input logic [7:0] data);
        return acc ^ data;
    endfunction

endpackage

// File: rtl/instr_loader_byte_packer.sv
// byte_packer: collects bytes MSB first into 32-bit words. Only the three
// older bytes are stored; the fourth comes straight from byte_in, so the
// complete word is presented in the same cycle that its last byte is accepted.
module byte_packer
    import mips_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    input  logic              clear,
    input  logic              shift_en,
    input  logic [7:0]        byte_in,
    output logic [WORD_W-1:0] word,
    output logic              word_valid
);

    logic [23:0] shift_r;
    logic [1:0]  cnt_r;

    // Shift accepted bytes in and count position within the current word.
    always_ff @(posedge clk) begin
        if (reset || clear) begin
            shift_r <= 24'd0;
            cnt_r   <= 2'd0;
        end else if (shift_en) begin
            shift_r <= {shift_r[15:0], byte_in};
            cnt_r   <= cnt_r + 2'd1;
        end else begin
            shift_r <= shift_r;
            cnt_r   <= cnt_r;
        end
    end

    // Present the assembled word and flag the fourth byte of each group.
    always_comb begin
        word       = {shift_r, byte_in};
        word_valid = shift_en && (cnt_r == 2'd3);
    end

endmodule

// File: rtl/instr_loader.sv
// instr_loader: receives a big-endian byte stream (count, entry PC, words),
// writes the words into instruction memory and holds the core PC at the
// entry address until the final word has been written.
// Optional trailing checksum byte: define INSTR_LOADER_CHECKSUM_EN.
module instr_loader
    import mips_pkg::*;
#(
    parameter int                IMEM_DEPTH = 2048,
    parameter int                BASE_WADDR = 0,
    parameter logic [WORD_W-1:0] DEFAULT_PC = 32'h0000_0000
)(
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   start,
    input  logic                   byte_valid,
    input  logic [7:0]             byte_data,
    output logic                   byte_ready,
    output logic [WORD_W-1:0]      instructionInput,
    output logic                   instructionWriteEnable,
    output logic [IMEM_ADDR_W-1:0] writeAddr,
    output logic [WORD_W-1:0]      PC,
    output logic                   PC_set,
    output logic                   busy,
    output logic                   error
);

    localparam logic [31:0]            MAX_WORDS = 32'(IMEM_DEPTH - BASE_WADDR);
    localparam logic [IMEM_ADDR_W-1:0] BASE_A    = IMEM_ADDR_W'(BASE_WADDR);
`ifdef INSTR_LOADER_CHECKSUM_EN
    localparam state_t END_STATE = CHK;
`else
    localparam state_t END_STATE = RUN;
`endif

    state_t state_r;
    state_t next_state_s;

    logic                   byte_ready_s;
    logic                   busy_s;
    logic                   pc_set_s;
    logic                   fire_s;
    logic [15:0]            hdr_count_s;

    logic                   hdr_idx_r;
    logic [15:0]            count_r;
    logic                   zero_len_r;
    logic [15:0]            word_idx_r;
    logic [WORD_W-1:0]      instr_r;
    logic                   we_r;
    logic [IMEM_ADDR_W-1:0] write_addr_r;
    logic [WORD_W-1:0]      pc_r;
    logic                   pc_set_r;
    logic                   error_r;
`ifdef INSTR_LOADER_CHECKSUM_EN
    logic [7:0]             xor_r;
`endif

    logic                   pack_clear_s;
    logic                   pack_shift_s;
    logic [WORD_W-1:0]      pack_word_s;
    logic                   pack_valid_s;

    // Handshake and packer control derived from the current state.
    always_comb begin
        fire_s       = byte_valid && byte_ready_s;
        hdr_count_s  = {count_r[15:8], byte_data};
        pack_clear_s = (state_r == IDLE);
        pack_shift_s = fire_s && ((state_r == ENTRY) || (state_r == DATA));
    end

    byte_packer u_packer (
        .clk        (clk),
        .reset      (reset),
        .clear      (pack_clear_s),
        .shift_en   (pack_shift_s),
        .byte_in    (byte_data),
        .word       (pack_word_s),
        .word_valid (pack_valid_s)
    );

    // State register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r <= IDLE;
        end else begin
            state_r <= next_state_s;
        end
    end

    // Next-state logic for the load session.
    always_comb begin
        next_state_s = state_r;
        case (state_r)
            IDLE: begin
                if (start) next_state_s = HDR;
                else       next_state_s = IDLE;
            end
            HDR: begin
                if (fire_s && hdr_idx_r) begin
                    if ({16'd0, hdr_count_s} > MAX_WORDS) next_state_s = ERR;
                    else                                  next_state_s = ENTRY;
                end else begin
                    next_state_s = HDR;
                end
            end
            ENTRY: begin
                if (pack_valid_s) begin
                    if (zero_len_r) next_state_s = END_STATE;
                    else            next_state_s = DATA;
                end else begin
                    next_state_s = ENTRY;
                end
            end
            DATA: begin
                if (pack_valid_s && (word_idx_r == (count_r - 16'd1))) next_state_s = END_STATE;
                else                                                   next_state_s = DATA;
            end
            CHK: begin
`ifdef INSTR_LOADER_CHECKSUM_EN
                if (fire_s) begin
                    if (byte_data == xor_r) next_state_s = RUN;
                    else                    next_state_s = ERR;
                end else begin
                    next_state_s = CHK;
                end
`else
                next_state_s = ERR;
`endif
            end
            RUN:     next_state_s = RUN;
            ERR:     next_state_s = ERR;
            default: next_state_s = ERR;
        endcase
    end

    // Per-state output decode.
    always_comb begin
        byte_ready_s = 1'b0;
        busy_s       = 1'b1;
        pc_set_s     = 1'b1;
        case (state_r)
            IDLE:  busy_s = 1'b0;
            HDR:   byte_ready_s = 1'b1;
            ENTRY: byte_ready_s = 1'b1;
            DATA:  byte_ready_s = 1'b1;
`ifdef INSTR_LOADER_CHECKSUM_EN
            CHK:   byte_ready_s = 1'b1;
`endif
            RUN: begin
                busy_s   = 1'b0;
                pc_set_s = 1'b0;
            end
            default: byte_ready_s = 1'b0;
        endcase
    end

    // Header capture, entry PC, word writes and the sticky error flag.
    always_ff @(posedge clk) begin
        if (reset) begin
            hdr_idx_r    <= 1'b0;
            count_r      <= 16'd0;
            zero_len_r   <= 1'b0;
            word_idx_r   <= 16'd0;
            instr_r      <= '0;
            we_r         <= 1'b0;
            write_addr_r <= BASE_A;
            pc_r         <= DEFAULT_PC;
            pc_set_r     <= 1'b1;
            error_r      <= 1'b0;
        end else begin
            we_r     <= 1'b0;
            // Release lags RUN entry by a cycle so it follows the last strobe.
            pc_set_r <= pc_set_s;
            case (state_r)
                IDLE: begin
                    if (start) begin
                        hdr_idx_r    <= 1'b0;
                        count_r      <= 16'd0;
                        zero_len_r   <= 1'b0;
                        word_idx_r   <= 16'd0;
                        write_addr_r <= BASE_A;
                    end
                end
                HDR: begin
                    if (fire_s) begin
                        if (!hdr_idx_r) begin
                            count_r[15:8] <= byte_data;
                            hdr_idx_r     <= 1'b1;
                        end else begin
                            count_r[7:0]  <= byte_data;
                            zero_len_r    <= (hdr_count_s == 16'd0);
                        end
                    end
                end
                ENTRY: begin
                    if (pack_valid_s) pc_r <= pack_word_s;
                end
                DATA: begin
                    if (pack_valid_s) begin
                        instr_r      <= pack_word_s;
                        we_r         <= 1'b1;
                        write_addr_r <= BASE_A + word_idx_r[IMEM_ADDR_W-1:0];
                        word_idx_r   <= word_idx_r + 16'd1;
                    end
                end
                default: ;
            endcase
            if (next_state_s == ERR) begin
                pc_r    <= DEFAULT_PC;
                error_r <= 1'b1;
            end
        end
    end

`ifdef INSTR_LOADER_CHECKSUM_EN
    // Running XOR of every header, entry and data byte.
    always_ff @(posedge clk) begin
        if (reset) begin
            xor_r <= 8'd0;
        end else if ((state_r == IDLE) && start) begin
            xor_r <= 8'd0;
        end else if (fire_s && (state_r != CHK)) begin
            xor_r <= xor_fold(xor_r, byte_data);
        end else begin
            xor_r <= xor_r;
        end
    end
`endif

    // Drive ports from state decode and registers.
    always_comb begin
        byte_ready             = byte_ready_s;
        busy                   = busy_s;
        instructionInput       = instr_r;
        instructionWriteEnable = we_r;
        writeAddr              = write_addr_r;
        PC                     = pc_r;
        PC_set                 = pc_set_r;
        error                  = error_r;
    end

endmodule

// File: tb/tb_instr_loader.sv
// Directed testbench for instr_loader. Inputs change 1 ns after the rising
// edge and outputs are checked there; write strobes are logged on the
// falling edge.
module tb_instr_loader;
    import mips_pkg::*;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic        byte_valid;
    logic [7:0]  byte_data;
    logic        byte_ready;
    logic [31:0] instructionInput;
    logic        instructionWriteEnable;
    logic [10:0] writeAddr;
    logic [31:0] PC;
    logic        PC_set;
    logic        busy;
    logic        error;

    int checks = 0;
    int errors = 0;

    logic [31:0] wr_data_q[$];
    logic [10:0] wr_addr_q[$];

    logic [7:0] normal_stream [14] = '{8'h00, 8'h02, 8'h00, 8'h40, 8'h00, 8'h00,
                                       8'h20, 8'h08, 8'h00, 8'h05, 8'h01, 8'h09, 8'h50, 8'h20};
    logic [7:0] zero_stream [6] = '{8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h80};

    instr_loader dut (
        .clk                    (clk),
        .reset                  (reset),
        .start                  (start),
        .byte_valid             (byte_valid),
        .byte_data              (byte_data),
        .byte_ready             (byte_ready),
        .instructionInput       (instructionInput),
        .instructionWriteEnable (instructionWriteEnable),
        .writeAddr              (writeAddr),
        .PC                     (PC),
        .PC_set                 (PC_set),
        .busy                   (busy),
        .error                  (error)
    );

    always #5 clk = ~clk;

    // Log every write strobe with its data and address.
    always @(negedge clk) begin
        if (instructionWriteEnable === 1'b1) begin
            wr_data_q.push_back(instructionInput);
            wr_addr_q.push_back(writeAddr);
        end
    end

    task automatic do_reset();
        reset = 1'b1; start = 1'b0; byte_valid = 1'b0; byte_data = 8'h00;
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        wr_data_q.delete();
        wr_addr_q.delete();
    endtask

    task automatic pulse_start();
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    // Present one byte after an optional idle gap; returns 1 ns after its transfer edge.
    task automatic send_byte(input logic [7:0] b, input int gap);
        int waited;
        byte_valid = 1'b0;
        for (int g = 0; g < gap; g++) begin
            @(posedge clk); #1;
        end
        byte_valid = 1'b1;
        byte_data  = b;
        waited     = 0;
        while (byte_ready !== 1'b1 && waited < 20) begin
            @(posedge clk); #1;
            waited++;
        end
        checks++;
        if (byte_ready !== 1'b1) begin
            errors++;
            $display("FAIL send_byte_ready byte=%h got ready=%b want 1", b, byte_ready);
        end
        @(posedge clk); #1;
        byte_valid = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        checks++; if (byte_ready !== 1'b0) begin errors++; $display("FAIL reset_byte_ready got %b want 0", byte_ready); end
        checks++; if (instructionWriteEnable !== 1'b0) begin errors++; $display("FAIL reset_we got %b want 0", instructionWriteEnable); end
        checks++; if (instructionInput !== 32'h0) begin errors++; $display("FAIL reset_instr got %h want 0", instructionInput); end
        checks++; if (writeAddr !== 11'd0) begin errors++; $display("FAIL reset_waddr got %0d want 0", writeAddr); end
        checks++; if (PC !== 32'h0) begin errors++; $display("FAIL reset_pc got %h want 0", PC); end
        checks++; if (PC_set !== 1'b1) begin errors++; $display("FAIL reset_pc_set got %b want 1", PC_set); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b want 0", busy); end
        checks++; if (error !== 1'b0) begin errors++; $display("FAIL reset_error got %b want 0", error); end
    endtask

    // Full load of the two-word program; max_gap > 0 inserts random idle cycles.
    task automatic test_normal_load(input int max_gap);
        do_reset();
        pulse_start();
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL load_busy got %b want 1", busy); end
        for (int i = 0; i < 14; i++) send_byte(normal_stream[i], (max_gap > 0) ? int'($urandom_range(0, max_gap)) : 0);
`ifdef INSTR_LOADER_CHECKSUM_EN
        send_byte(8'h17, 0);  // XOR of all 14 stream bytes
        @(posedge clk); #1;
`else
        // Cycle right after the last byte: second strobe high, core still held.
        checks++; if (instructionWriteEnable !== 1'b1) begin errors++; $display("FAIL load_last_strobe got %b want 1", instructionWriteEnable); end
        checks++; if (PC_set !== 1'b1) begin errors++; $display("FAIL load_pc_set_held got %b want 1", PC_set); end
        @(posedge clk); #1;
        checks++; if (instructionWriteEnable !== 1'b0) begin errors++; $display("FAIL load_strobe_width got %b want 0", instructionWriteEnable); end
`endif
        checks++; if (PC_set !== 1'b0) begin errors++; $display("FAIL load_pc_set_release got %b want 0", PC_set); end
        checks++; if (PC !== 32'h0040_0000) begin errors++; $display("FAIL load_pc got %h want 00400000", PC); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL load_busy_end got %b want 0", busy); end
        checks++; if (error !== 1'b0) begin errors++; $display("FAIL load_error got %b want 0", error); end
        checks++;
        if (wr_data_q.size() != 2) begin
            errors++; $display("FAIL load_write_count got %0d want 2", wr_data_q.size());
        end else begin
            checks++; if (wr_data_q[0] !== 32'h2008_0005) begin errors++; $display("FAIL load_word0 got %h want 20080005", wr_data_q[0]); end
            checks++; if (wr_addr_q[0] !== 11'd0) begin errors++; $display("FAIL load_addr0 got %0d want 0", wr_addr_q[0]); end
            checks++; if (wr_data_q[1] !== 32'h0109_5020) begin errors++; $display("FAIL load_word1 got %h want 01095020", wr_data_q[1]); end
            checks++; if (wr_addr_q[1] !== 11'd1) begin errors++; $display("FAIL load_addr1 got %0d want 1", wr_addr_q[1]); end
        end
        // start in RUN is ignored.
        pulse_start();
        @(posedge clk); #1;
        checks++; if (busy !== 1'b0 || byte_ready !== 1'b0) begin errors++; $display("FAIL run_start_ignored got busy=%b ready=%b want 0 0", busy, byte_ready); end
    endtask

    task automatic test_overflow();
        do_reset();
        pulse_start();
        send_byte(8'h08, 0);
        send_byte(8'h01, 0);
        @(posedge clk); #1;
        checks++; if (error !== 1'b1) begin errors++; $display("FAIL ovf_error got %b want 1", error); end
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL ovf_busy got %b want 1", busy); end
        checks++; if (byte_ready !== 1'b0) begin errors++; $display("FAIL ovf_ready got %b want 0", byte_ready); end
        checks++; if (PC_set !== 1'b1) begin errors++; $display("FAIL ovf_pc_set got %b want 1", PC_set); end
        checks++; if (wr_data_q.size() != 0) begin errors++; $display("FAIL ovf_writes got %0d want 0", wr_data_q.size()); end
    endtask

    task automatic test_zero_length();
        do_reset();
        pulse_start();
        for (int i = 0; i < 6; i++) send_byte(zero_stream[i], 0);
`ifdef INSTR_LOADER_CHECKSUM_EN
        send_byte(8'h80, 0);
`endif
        @(posedge clk); #1;
        checks++; if (PC_set !== 1'b0) begin errors++; $display("FAIL zero_pc_set got %b want 0", PC_set); end
        checks++; if (PC !== 32'h0000_0080) begin errors++; $display("FAIL zero_pc got %h want 00000080", PC); end
        checks++; if (wr_data_q.size() != 0) begin errors++; $display("FAIL zero_writes got %0d want 0", wr_data_q.size()); end
    endtask

    task automatic test_reset_mid();
        do_reset();
        pulse_start();
        for (int i = 0; i < 11; i++) send_byte(normal_stream[i], 0);  // header, entry, 5 data bytes
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL mid_busy got %b want 0", busy); end
        checks++; if (instructionWriteEnable !== 1'b0) begin errors++; $display("FAIL mid_we got %b want 0", instructionWriteEnable); end
        checks++; if (writeAddr !== 11'd0) begin errors++; $display("FAIL mid_waddr got %0d want 0", writeAddr); end
        checks++; if (PC_set !== 1'b1) begin errors++; $display("FAIL mid_pc_set got %b want 1", PC_set); end
        checks++; if (byte_ready !== 1'b0) begin errors++; $display("FAIL mid_ready got %b want 0", byte_ready); end
    endtask

`ifdef INSTR_LOADER_CHECKSUM_EN
    task automatic test_checksum_bad();
        do_reset();
        pulse_start();
        for (int i = 0; i < 14; i++) send_byte(normal_stream[i], 0);
        send_byte(8'h16, 0);
        @(posedge clk); #1;
        checks++; if (error !== 1'b1) begin errors++; $display("FAIL chk_error got %b want 1", error); end
        checks++; if (PC_set !== 1'b1) begin errors++; $display("FAIL chk_pc_set got %b want 1", PC_set); end
        checks++; if (PC !== 32'h0) begin errors++; $display("FAIL chk_pc got %h want 0", PC); end
    endtask
`endif

    initial begin
        test_reset();
        test_normal_load(0);
        test_normal_load(3);
        test_overflow();
        test_zero_length();
        test_reset_mid();
        test_normal_load(0);
`ifdef INSTR_LOADER_CHECKSUM_EN
        test_checksum_bad();
`endif
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    // Watchdog so the run always ends.
    initial begin
        #200000;
        $display("FAIL watchdog got timeout want completion");
        $fatal(1, "timeout");
    end

endmodule
